// File: rtl/conv_encoder_rn_pkg.sv
// Shared constants, FSM encoding and generator-mask helper for the
// programmable rate-1/N convolutional encoder.
package conv_pkg;
    localparam int K_MAX = 9;
    localparam int N_MAX = 4;
    localparam int PH_W  = 3;   // puncture phase, period up to 8
    localparam int CNT_W = 4;   // tail counter, M up to 8

    localparam logic [31:0] G_K7_R2 = {16'o171, 16'o133};
    localparam logic [31:0] G_K9_R2 = {16'o753, 16'o561};

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_TAIL = 1'b1
    } fsm_t;

    // Octal LSB is the oldest tap; anything at or above K is not a tap.
    function automatic logic [K_MAX-1:0] oct2mask(input logic [15:0] g, input int k);
        logic [K_MAX-1:0] m;
        for (int j = 0; j < K_MAX; j++) m[j] = (j < k) ? g[j] : 1'b0;
        return m;
    endfunction
endpackage

// File: rtl/conv_encoder_rn_if.sv
// Input/output valid-ready bus of the encoder; master drives bits in and
// accepts symbols, slave is the encoder.
interface conv_encoder_rn_if #(parameter int N_OUT = 2);
    logic             in_valid;
    logic             in_ready;
    logic             in_bit;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [N_OUT-1:0] out_sym;
    logic [N_OUT-1:0] out_keep;
    logic             out_last;

    modport master (
        output in_valid, in_bit, in_last, out_ready,
        input  in_ready, out_valid, out_sym, out_keep, out_last
    );
    modport slave (
        input  in_valid, in_bit, in_last, out_ready,
        output in_ready, out_valid, out_sym, out_keep, out_last
    );
endinterface

// File: rtl/conv_encoder_rn_sym_gen.sv
// Combinational parity of {b, state} against each generator mask.
module conv_sym_gen #(
    parameter int K     = 7,
    parameter int N_OUT = 2
) (
    input  logic                       b,
    input  logic [K-2:0]               state,
    input  logic [N_OUT-1:0][K-1:0]    masks,
    output logic [N_OUT-1:0]           sym
);
    for (genvar i = 0; i < N_OUT; i++) begin : g_gen
        assign sym[N_OUT-1-i] = ^({b, state} & masks[i]);
    end
endmodule

// File: rtl/conv_encoder_rn.sv
// Rate-1/N convolutional encoder: RUN/TAIL control, puncture phase,
// single-stage output register with valid/ready on both sides.
module conv_encoder_rn
    import conv_pkg::*;
#(
    parameter int                         K         = 7,
    parameter int                         N_OUT     = 2,
    parameter logic [16*N_OUT-1:0]        G_OCT     = G_K7_R2,
    parameter int                         PUNCT_P   = 1,
    parameter logic [N_OUT*PUNCT_P-1:0]   PUNCT_PAT = '1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         seed_load,
    input  logic [K-2:0] seed_value,
    input  logic         term_mode,
    conv_encoder_rn_if.slave bus
);
    localparam int M = K - 1;

    logic [N_OUT-1:0][K-1:0] masks;
    for (genvar i = 0; i < N_OUT; i++) begin : g_mask
        localparam logic [K_MAX-1:0] MF = oct2mask(G_OCT[16*(N_OUT-1-i) +: 16], K);
        assign masks[i] = MF[K-1:0];
    end

    fsm_t             fsm_q, fsm_d;
    logic [M-1:0]     state_q;
    logic [PH_W-1:0]  phase_q;
    logic [CNT_W-1:0] tail_q;
    logic             out_valid_q, out_last_q;
    logic [N_OUT-1:0] out_sym_q, out_keep_q;

    logic             ld_ok, in_rdy, in_xfer, tail_go, seed_ok, b;
    logic [N_OUT-1:0] sym, keep_cur;

    assign ld_ok   = !out_valid_q || bus.out_ready;
    assign in_xfer = bus.in_valid && in_rdy;
    assign seed_ok = seed_load && (fsm_q == ST_RUN);
    assign b       = (fsm_q == ST_TAIL) ? 1'b0 : bus.in_bit;

    conv_sym_gen #(.K(K), .N_OUT(N_OUT)) u_sym (
        .b     (b),
        .state (state_q),
        .masks (masks),
        .sym   (sym)
    );

    always_comb begin
        keep_cur = '0;
        for (int p = 0; p < PUNCT_P; p++)
            if (phase_q == PH_W'(p)) keep_cur = PUNCT_PAT[N_OUT*p +: N_OUT];
    end

    always_comb begin
        fsm_d   = fsm_q;
        in_rdy  = 1'b0;
        tail_go = 1'b0;
        case (fsm_q)
            ST_RUN: begin
                in_rdy = rst_n && !seed_load && ld_ok;
                if (bus.in_valid && in_rdy && bus.in_last && term_mode) fsm_d = ST_TAIL;
            end
            ST_TAIL: begin
                tail_go = ld_ok;
                if (ld_ok && tail_q == '0) fsm_d = ST_RUN;
            end
            default: fsm_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) fsm_q <= ST_RUN;
        else        fsm_q <= fsm_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= '0;
            phase_q     <= '0;
            tail_q      <= CNT_W'(M-1);
            out_valid_q <= 1'b0;
            out_sym_q   <= '0;
            out_keep_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            if (in_xfer || tail_go) begin
                out_valid_q <= 1'b1;
                out_sym_q   <= sym;
                out_keep_q  <= tail_go ? '1 : keep_cur;
                out_last_q  <= tail_go ? (tail_q == '0) : (bus.in_last && !term_mode);
                state_q     <= {b, state_q[M-1:1]};
            end else begin
                if (ld_ok)   out_valid_q <= 1'b0;
                if (seed_ok) state_q     <= seed_value;
            end

            // Tail symbols leave the puncture phase untouched.
            if (in_xfer)
                phase_q <= (bus.in_last || phase_q == PH_W'(PUNCT_P-1)) ? '0 : phase_q + PH_W'(1);
            else if (seed_ok)
                phase_q <= '0;

            if (tail_go)
                tail_q <= (tail_q == '0) ? CNT_W'(M-1) : tail_q - CNT_W'(1);
        end
    end

    assign bus.in_ready  = in_rdy;
    assign bus.out_valid = out_valid_q;
    assign bus.out_sym   = out_sym_q;
    assign bus.out_keep  = out_keep_q;
    assign bus.out_last  = out_last_q;
endmodule

// File: tb/tb_conv_encoder_rn.sv
// Scoreboard bench: three encoder configurations checked against a
// delay-indexed parity model, with directed tables for the known sequences.
module tb_conv_encoder_rn;
    import conv_pkg::*;

    localparam int          KA = 7, NA = 2, PA = 3;
    localparam logic [31:0] GA = G_K7_R2;
    localparam logic [5:0]  PATA = 6'b100111;
    localparam int          KB = 9, NB = 2;
    localparam logic [31:0] GB = G_K9_R2;
    localparam int          NC = 3, PC = 2;
    localparam logic [47:0] GC = {16'o557, 16'o663, 16'o711};
    localparam logic [5:0]  PATC = 6'b011111;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic          seed_a = 1'b0, term_a = 1'b0, term_bc = 1'b0, seed_bc = 1'b0;
    logic [KA-2:0] seedv_a = '0;
    logic [KB-2:0] seedv_bc = '0;

    conv_encoder_rn_if #(.N_OUT(NA)) ia ();
    conv_encoder_rn_if #(.N_OUT(NB)) ib ();
    conv_encoder_rn_if #(.N_OUT(NC)) ic ();

    conv_encoder_rn #(.K(KA), .N_OUT(NA), .G_OCT(GA), .PUNCT_P(PA), .PUNCT_PAT(PATA)) dut_a (
        .clk(clk), .rst_n(rst_n), .seed_load(seed_a), .seed_value(seedv_a),
        .term_mode(term_a), .bus(ia));
    conv_encoder_rn #(.K(KB), .N_OUT(NB), .G_OCT(GB), .PUNCT_P(1), .PUNCT_PAT(2'b11)) dut_b (
        .clk(clk), .rst_n(rst_n), .seed_load(seed_bc), .seed_value(seedv_bc),
        .term_mode(term_bc), .bus(ib));
    conv_encoder_rn #(.K(KB), .N_OUT(NC), .G_OCT(GC), .PUNCT_P(PC), .PUNCT_PAT(PATC)) dut_c (
        .clk(clk), .rst_n(rst_n), .seed_load(seed_bc), .seed_value(seedv_bc),
        .term_mode(term_bc), .bus(ic));

    int n_chk = 0, n_pass = 0;
    int rmode_a = 0, rmode_bc = 0;   // 0 ready, 1 random, 2 stalled
    logic [8:0]  qa[$], qb[$], qc[$];
    logic [4:0]  loga[$];
    logic [15:0] past_a = '0, past_bc = '0;   // bit d-1 = input d steps ago
    int ph_a = 0, ph_c = 0;
    logic [4:0] imp_tab [7] = '{5'b0_11_11, 5'b0_11_10, 5'b0_11_11, 5'b0_11_11,
                                5'b0_11_00, 5'b0_11_01, 5'b1_11_11};
    logic [1:0] pk_tab [8] = '{2'b11, 2'b01, 2'b10, 2'b11, 2'b01, 2'b10, 2'b11, 2'b11};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h", nm, act, exp);
    endtask

    task automatic bad(input string nm);
        n_chk++;
        $display("FAIL %s: bound expired or unexpected event", nm);
    endtask

    function automatic logic [3:0] enc(int k, int n, logic [63:0] gens, logic [15:0] past, logic b);
        logic [3:0] s; logic [15:0] g; logic p;
        s = '0;
        for (int i = 0; i < n; i++) begin
            g = gens[16*(n-1-i) +: 16];
            p = g[k-1] & b;
            for (int d = 1; d < k; d++) p ^= g[k-1-d] & past[d-1];
            s[n-1-i] = p;
        end
        return s;
    endfunction

    function automatic logic [3:0] keep_of(int n, logic [31:0] pat, int ph);
        logic [31:0] v;
        v = (pat >> (n*ph)) & ((32'd1 << n) - 32'd1);
        return v[3:0];
    endfunction

    function automatic logic [8:0] pk(logic last, logic [3:0] keep, logic [3:0] sym);
        return {last, keep, sym};
    endfunction

    task automatic push_a(input logic b, input logic last, input logic tm);
        qa.push_back(pk(last && !tm, keep_of(NA, 32'(PATA), ph_a), enc(KA, NA, 64'(GA), past_a, b)));
        past_a = {past_a[14:0], b};
        ph_a = last ? 0 : (ph_a + 1) % PA;
        if (last && tm)
            for (int t = 1; t < KA; t++) begin
                qa.push_back(pk(t == KA-1, 4'b0011, enc(KA, NA, 64'(GA), past_a, 1'b0)));
                past_a = {past_a[14:0], 1'b0};
            end
    endtask

    task automatic push_bc(input logic b, input logic last, input logic tm);
        qb.push_back(pk(last && !tm, keep_of(NB, 32'b11, 0), enc(KB, NB, 64'(GB), past_bc, b)));
        qc.push_back(pk(last && !tm, keep_of(NC, 32'(PATC), ph_c), enc(KB, NC, 64'(GC), past_bc, b)));
        past_bc = {past_bc[14:0], b};
        ph_c = last ? 0 : (ph_c + 1) % PC;
        if (last && tm)
            for (int t = 1; t < KB; t++) begin
                qb.push_back(pk(t == KB-1, 4'b0011, enc(KB, NB, 64'(GB), past_bc, 1'b0)));
                qc.push_back(pk(t == KB-1, 4'b0111, enc(KB, NC, 64'(GC), past_bc, 1'b0)));
                past_bc = {past_bc[14:0], 1'b0};
            end
    endtask

    task automatic send_a(input logic b, input logic last, input logic tm);
        int t;
        t = 0;
        ia.in_valid = 1'b1; ia.in_bit = b; ia.in_last = last; term_a = tm;
        @(negedge clk);
        while (!ia.in_ready && t < 300) begin @(negedge clk); t++; end
        if (ia.in_ready) push_a(b, last, tm); else bad("a_accept");
        @(posedge clk); #1;
        ia.in_valid = 1'b0;
    endtask

    task automatic send_bc(input logic b, input logic last, input logic tm);
        int t;
        t = 0;
        ib.in_valid = 1'b1; ib.in_bit = b; ib.in_last = last;
        ic.in_valid = 1'b1; ic.in_bit = b; ic.in_last = last; term_bc = tm;
        @(negedge clk);
        while (!ib.in_ready && t < 300) begin @(negedge clk); t++; end
        if (ib.in_ready && ic.in_ready) push_bc(b, last, tm); else bad("bc_accept");
        @(posedge clk); #1;
        ib.in_valid = 1'b0; ic.in_valid = 1'b0;
    endtask

    task automatic drain_a();
        int t;
        t = 0;
        while (qa.size() != 0 && t < 500) begin @(negedge clk); t++; end
        if (qa.size() != 0) bad("a_drain");
        @(posedge clk); #1;
    endtask

    task automatic drain_bc();
        int t;
        t = 0;
        while ((qb.size() != 0 || qc.size() != 0) && t < 2000) begin @(negedge clk); t++; end
        if (qb.size() != 0 || qc.size() != 0) bad("bc_drain");
        @(posedge clk); #1;
    endtask

    task automatic seed_load_a(input logic [KA-2:0] v);
        drain_a();
        seed_a = 1'b1; seedv_a = v; ia.in_valid = 1'b1; ia.in_bit = 1'b1; ia.in_last = 1'b0;
        @(negedge clk);
        chk("seed_blocks_in_ready", ia.in_ready, 0);
        past_a = '0;
        for (int d = 1; d < KA; d++) past_a[d-1] = v[KA-1-d];
        ph_a = 0;
        @(posedge clk); #1;
        seed_a = 1'b0; ia.in_valid = 1'b0;
    endtask

    task automatic check_imp();
        chk("imp_count", loga.size(), 7);
        for (int i = 0; i < 7; i++) chk("imp_sym", loga[i], imp_tab[i]);
    endtask

    always @(posedge clk) begin
        #2;
        ia.out_ready = (rmode_a == 0) || (rmode_a == 1 && $urandom_range(0, 2) != 0);
        ib.out_ready = (rmode_bc == 0) || (rmode_bc == 1 && $urandom_range(0, 2) != 0);
        ic.out_ready = ib.out_ready;
    end

    always @(negedge clk) begin
        if (rst_n && ia.out_valid && ia.out_ready) begin
            loga.push_back({ia.out_last, ia.out_keep, ia.out_sym});
            if (qa.size() == 0) bad("a_extra_symbol");
            else chk("a_sym", {23'b0, ia.out_last, 2'b0, ia.out_keep, 2'b0, ia.out_sym}, {23'b0, qa.pop_front()});
        end
        if (rst_n && ib.out_valid && ib.out_ready) begin
            if (qb.size() == 0) bad("b_extra_symbol");
            else chk("b_sym", {23'b0, ib.out_last, 2'b0, ib.out_keep, 2'b0, ib.out_sym}, {23'b0, qb.pop_front()});
        end
        if (rst_n && ic.out_valid && ic.out_ready) begin
            if (qc.size() == 0) bad("c_extra_symbol");
            else chk("c_sym", {23'b0, ic.out_last, 1'b0, ic.out_keep, 1'b0, ic.out_sym}, {23'b0, qc.pop_front()});
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $display("%0d/%0d checks passed", n_pass, n_chk + 1);
        $fatal(1);
    end

    initial begin
        int len, t;
        logic tm;
        logic [4:0] e;
        ia.in_valid = 0; ia.in_bit = 0; ia.in_last = 0;
        ib.in_valid = 0; ib.in_bit = 0; ib.in_last = 0;
        ic.in_valid = 0; ic.in_bit = 0; ic.in_last = 0;
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("rst_valid", ia.out_valid, 0);
        chk("rst_sym", ia.out_sym, 0);
        chk("rst_keep", ia.out_keep, 0);
        chk("rst_last", ia.out_last, 0);
        chk("rst_in_ready", ia.in_ready, 0);
        chk("rst_b_valid", ib.out_valid, 0);
        chk("rst_c_in_ready", ic.in_ready, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // impulse with zero tail
        loga.delete();
        send_a(1'b1, 1'b1, 1'b1);
        drain_a();
        check_imp();

        // truncated frame 1,0,1
        loga.delete();
        send_a(1'b1, 1'b0, 1'b0);
        send_a(1'b0, 1'b0, 1'b0);
        send_a(1'b1, 1'b1, 1'b0);
        @(negedge clk);
        chk("trunc_in_ready", ia.in_ready, 1);
        drain_a();
        chk("trunc_count", loga.size(), 3);
        chk("trunc_0", loga[0], 5'b0_11_11);
        chk("trunc_1", loga[1], 5'b0_01_10);
        chk("trunc_2", loga[2], 5'b1_10_00);

        // puncture phase over 7 bits, then restart on the next frame
        loga.delete();
        for (int i = 0; i < 7; i++) send_a(1'($urandom_range(0, 1)), i == 6, 1'b0);
        send_a(1'($urandom_range(0, 1)), 1'b1, 1'b1);
        drain_a();
        for (int i = 0; i < 8; i++) begin
            e = loga[i];
            chk("punct_keep", e[3:2], pk_tab[i]);
        end

        // output stall
        rmode_a = 2;
        send_a(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", ia.out_valid, 1);
            chk("bp_in_ready", ia.in_ready, 0);
            chk("bp_hold", {23'b0, ia.out_last, 2'b0, ia.out_keep, 2'b0, ia.out_sym}, {23'b0, qa[0]});
        end
        @(posedge clk); #1;
        rmode_a = 0;
        for (int i = 0; i < 6; i++) send_a(1'($urandom_range(0, 1)), i == 5, 1'b1);
        drain_a();

        // seed
        seed_load_a(6'b000001);
        loga.delete();
        send_a(1'b0, 1'b1, 1'b0);
        drain_a();
        chk("seed_count", loga.size(), 1);
        chk("seed_sym", loga[0], 5'b1_11_11);

        // reset during tail
        loga.delete();
        send_a(1'b1, 1'b1, 1'b1);
        t = 0;
        while (loga.size() < 3 && t < 100) begin @(negedge clk); t++; end
        if (loga.size() < 3) bad("tail_wait");
        @(posedge clk); #3 rst_n = 1'b0;
        #1;
        chk("rst_tail_valid", ia.out_valid, 0);
        chk("rst_tail_in_ready", ia.in_ready, 0);
        qa.delete(); past_a = '0; ph_a = 0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_run_in_ready", ia.in_ready, 1);
        @(posedge clk); #1;
        loga.delete();
        send_a(1'b1, 1'b1, 1'b1);
        drain_a();
        check_imp();

        // random frames on A with random output ready and occasional seeds
        rmode_a = 1;
        for (int f = 0; f < 6; f++) begin
            len = $urandom_range(1, 20);
            tm = 1'($urandom_range(0, 1));
            if (f == 3) seed_load_a(6'($urandom));
            for (int i = 0; i < len; i++) send_a(1'($urandom_range(0, 1)), i == len-1, tm);
        end
        drain_a();

        // 200-bit random frames on K=9 rate-1/2 and rate-1/3
        rmode_bc = 1;
        for (int f = 0; f < 3; f++) begin
            tm = (f != 1);
            for (int i = 0; i < 200; i++) send_bc(1'($urandom_range(0, 1)), i == 199, tm);
        end
        drain_bc();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/conv_encoder_rn.md
# conv_encoder_rn

Rate-1/N convolutional encoder with programmable constraint length, up to four generators, periodic puncturing signalled as a per-bit keep mask, and frame termination (zero-tail or truncated). It replaces the fixed rate-1/2 encoder at the front of the Viterbi datapath. It adds valid/ready backpressure on both sides, so it can feed the channel model and decoder test harnesses directly.

## Interface
- `K`, 7: constraint length, 3..9; `M = K-1` memory bits.
- `N_OUT`, 2: generators/output bits per symbol, 2..4.
- `G_OCT`, {16'o171,16'o133}: generators, 16 bits each; generator i at `G_OCT[16*(N_OUT-1-i) +: 16]` (G0 in the MSB slice).
- `PUNCT_P`, 1: puncture period, 1..8.
- `PUNCT_PAT`, all ones: `N_OUT*PUNCT_P` bits; the phase-p keep mask is `PUNCT_PAT[N_OUT*p +: N_OUT]`.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `seed_load` in 1: load `seed_value` into the encoder state.
- `seed_value` in M: initial state.
- `term_mode` in 1: 0 = truncated, 1 = zero-tail; sampled when `in_last` is accepted.
- `in_valid` in 1 / `in_ready` out 1: input handshake.
- `in_bit` in 1: information bit.
- `in_last` in 1: final information bit of the frame.
- `out_valid` out 1 / `out_ready` in 1: output handshake.
- `out_sym` out N_OUT: coded bits; `out_sym[N_OUT-1-i]` is the generator-i output.
- `out_keep` out N_OUT: 1 = transmit the bit, 0 = punctured (erasure).
- `out_last` out 1: last symbol of the frame.

## Operation
- Octal-to-mask conversion: octal LSB maps to mask bit 0, which is the oldest tap. Bits at or above K are dropped.
- Register vector `{b, state}`. Symbol bit for generator i = `^(vec & mask_i)`. Next state = `{b, state[M-1:1]}`.
- FSM states:
  - RUN: an input transfer happens when `in_valid && in_ready`.
  - TAIL: the block generates M symbols internally with b=0.
- RUN to TAIL occurs when `in_last` is accepted with `term_mode=1`.
- TAIL to RUN occurs when the M-th tail symbol is loaded into the output register. A tail counter counts M-1 down to 0.
- Puncture phase counter runs 0..PUNCT_P-1 and advances on each information symbol. `out_keep` for an information symbol equals the pattern at the current phase.
- Tail symbols always have `out_keep` all ones and do not advance the phase.
- The phase resets to 0 on `in_last` acceptance and on `seed_load`.
- `out_last` marks the following symbol:
  - truncated mode: the `in_last` symbol.
  - zero-tail mode: the M-th tail symbol.
- `seed_load` is honoured only in RUN. It forces `in_ready=0` that cycle, so it takes priority over any input transfer. It is ignored in TAIL.
- Output register: a single stage. It loads whenever `!out_valid || out_ready` and a symbol source exists (an input transfer, or TAIL).

## Timing
- Reset values:
  - `out_valid=0`, `out_sym=0`, `out_keep=0`, `out_last=0`.
  - state=0, phase=0, FSM=RUN, tail count=M-1.
  - `in_ready=0` while `rst_n` is low.
- `in_ready = (FSM==RUN) && !seed_load && (!out_valid || out_ready)`. This is combinational and has no reset hazard after release.
- Latency: an input accepted at edge n produces `out_valid` with that symbol after edge n.
- Throughput: 1 symbol/cycle when `out_ready` is held high. A zero-tail frame of L bits occupies L+M output cycles.
- Backpressure: while `out_valid && !out_ready`, `out_sym`/`out_keep`/`out_last` hold and the state, phase, and tail count freeze.
- `in_ready` is low for the whole TAIL period. The next frame's first bit can be accepted in the cycle the last tail symbol is accepted.
- Asserting `rst_n` low at any point, including mid-TAIL, clears all state immediately.

## Structure
- Package `conv_pkg`:
  - `oct2mask` function.
  - `K_MAX=9`, `N_MAX=4`.
  - Default generator constants (K=7 171/133, K=9 753/561).
  - FSM state enum.
- Sub-module `conv_sym_gen`: combinational (b, state, masks) to N_OUT bits. It is instantiated once. The top holds the FSM, counters, and output register.

## Test plan
- Impulse, K=7, (171,133), `term_mode=1`, single bit 1 with `in_last`:
  - 7 symbols: 11,10,11,11,00,01,11.
  - `out_last` only on the 7th symbol.
  - `out_keep=11` throughout.
- Truncated mode, frame 1,0,1 with `in_last` on the third bit:
  - 3 symbols: 11,10,00.
  - `out_last` on the third symbol.
  - `in_ready` stays high.
- Puncturing, `PUNCT_P=3`, `PUNCT_PAT=6'b100111`, 7 info bits:
  - `out_keep` sequence 11,01,10,11,01,10,11.
  - The phase restarts at 11 for the next frame.
- Backpressure: hold `out_ready=0` for 5 cycles with `out_valid=1`:
  - Outputs stay stable and `in_ready=0`.
  - After release, the symbol stream matches the golden model with no loss or duplication.
- Seed: `seed_load` with `6'b000001`, then `in_bit=0`:
  - `out_sym=11`.
  - `seed_load` asserted together with `in_valid` leaves no input transfer that cycle.
- Reset mid-TAIL: drop `rst_n` on the 3rd tail symbol:
  - `out_valid` goes to 0 immediately.
  - After release, the state is 0, the FSM is RUN, and a new impulse reproduces the first scenario.
- Random 200-bit frames against the golden model for K=9 (753,561) with N_OUT=2, and for N_OUT=3.
